// File: rtl/synth_transport_pkg.sv
// Shared transport definitions: state codes, state type and counter width helper.
package synth_transport_pkg;

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    typedef enum logic [1:0] {
        S_STOP    = ST_STOP,
        S_PLAY    = ST_PLAY,
        S_PAUSE   = ST_PAUSE,
        S_ILLEGAL = 2'd3
    } transport_state_t;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/transport_ctrl_if.sv
// Button inputs and transport outputs between the playback engines and transport_ctrl.
interface transport_ctrl_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]   btn_ch;
    logic                  btn_all;
    logic [CHANNELS-1:0]   run;
    logic [CHANNELS-1:0]   rewind;
    logic [2*CHANNELS-1:0] state;

    modport master (output btn_ch, output btn_all, input run, input rewind, input state);
    modport slave  (input btn_ch, input btn_all, output run, output rewind, output state);
endinterface

// File: rtl/transport_ctrl_button_conditioner.sv
// Synchroniser, debounce and press classification for one raw button.
// TRANSPORT_LONG_PRESS_EN adds the hold counter and long pulses; otherwise the press edge is the short event.
module button_conditioner
    import synth_transport_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
`ifdef TRANSPORT_LONG_PRESS_EN
    ,
    parameter int HOLD_CYCLES     = 25000000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_short
`ifdef TRANSPORT_LONG_PRESS_EN
    ,
    output logic o_long
`endif
);
    localparam int             DW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0]  DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync0, r_sync1;
    logic [1:0]    r_valid;
    logic [DW-1:0] r_db_cnt;
    logic          r_db, r_db_d;
    logic          r_armed;
    logic          r_short;

    // r_armed stays low until the button is seen released after reset, so a press
    // held through reset never produces an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync0  <= 1'b0;
            r_sync1  <= 1'b0;
            r_valid  <= 2'b00;
            r_db_cnt <= '0;
            r_db     <= 1'b0;
            r_db_d   <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_sync0 <= i_btn;
            r_sync1 <= r_sync0;
            r_valid <= {r_valid[0], 1'b1};
            r_db_d  <= r_db;
            if (r_sync1 == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_db     <= r_sync1;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
            if (r_valid[1] && !r_sync1 && !r_db) begin
                r_armed <= 1'b1;
            end
        end
    end

`ifdef TRANSPORT_LONG_PRESS_EN
    localparam int            HW       = cnt_width(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(HOLD_CYCLES - 1);

    logic [HW-1:0] r_hold;
    logic          r_long;

    // A saturated hold count means long already fired for this press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold  <= '0;
            r_long  <= 1'b0;
            r_short <= 1'b0;
        end else begin
            if (!r_db) begin
                r_hold <= '0;
            end else if (r_hold != HOLD_MAX) begin
                r_hold <= r_hold + 1'b1;
            end
            r_long  <= r_armed && r_db && (r_hold == HOLD_PRE);
            r_short <= r_armed && r_db_d && !r_db && (r_hold != HOLD_MAX);
        end
    end

    assign o_long = r_long;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_short <= 1'b0;
        end else begin
            r_short <= r_armed && r_db && !r_db_d;
        end
    end
`endif

    assign o_short = r_short;

endmodule

// File: rtl/transport_ctrl.sv
// Per-channel STOP/PLAY/PAUSE transport FSMs driven by channel and global buttons.
// TRANSPORT_LONG_PRESS_EN enables long presses (STOP with rewind); otherwise rewind is held at 0.
module transport_ctrl
    import synth_transport_pkg::*;
#(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 50000
`ifdef TRANSPORT_LONG_PRESS_EN
    ,
    parameter int HOLD_CYCLES     = 25000000
`endif
) (
    input logic             clk,
    input logic             reset,
    transport_ctrl_if.slave bus
);
    // Index CHANNELS carries the global button.
    logic [CHANNELS:0] w_btn;
    logic [CHANNELS:0] w_short;
`ifdef TRANSPORT_LONG_PRESS_EN
    logic [CHANNELS:0] w_long;
    logic              r_rewind [CHANNELS];
`endif
    transport_state_t  r_state [CHANNELS];
    logic              w_any_play;

    assign w_btn = {bus.btn_all, bus.btn_ch};

    genvar gi;
    generate
        for (gi = 0; gi <= CHANNELS; gi++) begin : g_btn
            button_conditioner #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef TRANSPORT_LONG_PRESS_EN
                ,
                .HOLD_CYCLES(HOLD_CYCLES)
`endif
            ) u_cond (
                .clk    (clk),
                .reset  (reset),
                .i_btn  (w_btn[gi]),
                .o_short(w_short[gi])
`ifdef TRANSPORT_LONG_PRESS_EN
                ,
                .o_long (w_long[gi])
`endif
            );
        end

        // Channel events take priority; the global short uses the pre-update any-PLAY test.
        for (gi = 0; gi < CHANNELS; gi++) begin : g_fsm
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state[gi]  <= S_STOP;
`ifdef TRANSPORT_LONG_PRESS_EN
                    r_rewind[gi] <= 1'b0;
`endif
                end else begin
`ifdef TRANSPORT_LONG_PRESS_EN
                    r_rewind[gi] <= 1'b0;
`endif
                    case (r_state[gi])
                        S_STOP, S_PLAY, S_PAUSE: begin
                            if (w_short[gi]) begin
                                r_state[gi] <= (r_state[gi] == S_PLAY) ? S_PAUSE : S_PLAY;
                            end
`ifdef TRANSPORT_LONG_PRESS_EN
                            else if (w_long[gi] || w_long[CHANNELS]) begin
                                if (r_state[gi] != S_STOP) begin
                                    r_state[gi]  <= S_STOP;
                                    r_rewind[gi] <= 1'b1;
                                end
                            end
`endif
                            else if (w_short[CHANNELS]) begin
                                if (w_any_play && (r_state[gi] == S_PLAY)) begin
                                    r_state[gi] <= S_PAUSE;
                                end else if (!w_any_play && (r_state[gi] == S_PAUSE)) begin
                                    r_state[gi] <= S_PLAY;
                                end
                            end
                        end
                        default: r_state[gi] <= S_STOP;
                    endcase
                end
            end
        end
    endgenerate

    always_comb begin
        w_any_play = 1'b0;
        bus.run    = '0;
        bus.state  = '0;
        bus.rewind = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            bus.run[i]          = (r_state[i] == S_PLAY);
            bus.state[2*i +: 2] = r_state[i];
            w_any_play          = w_any_play | (r_state[i] == S_PLAY);
`ifdef TRANSPORT_LONG_PRESS_EN
            bus.rewind[i]       = r_rewind[i];
`endif
        end
    end

endmodule

// File: tb/tb_transport_ctrl.sv
// Self-checking bench for transport_ctrl with a press-level behavioural model.
module tb_transport_ctrl;
    localparam int CH   = 2;
    localparam int DB   = 4;
    localparam int HOLD = 16;
`ifdef TRANSPORT_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif
    localparam int E_STOP  = 0;
    localparam int E_PLAY  = 1;
    localparam int E_PAUSE = 2;
    localparam int SETTLE  = 20;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    transport_ctrl_if #(.CHANNELS(CH)) bus ();

    transport_ctrl #(
        .CHANNELS(CH),
        .DEBOUNCE_CYCLES(DB)
`ifdef TRANSPORT_LONG_PRESS_EN
        ,
        .HOLD_CYCLES(HOLD)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_state [CH];
    int exp_rew   [CH];
    int rew_cnt   [CH];
    int rew_bad = 0;
    logic [1:0] prev_st [CH];
    logic prev_rst = 1'b0;

    // Rewind monitor: counts pulses and flags any pulse not coinciding with a fresh entry into STOP.
    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) begin
            if (reset && prev_rst) begin
                if (bus.rewind[i]) begin
                    rew_cnt[i]++;
                    if (!(bus.state[2*i +: 2] == 2'd0 && prev_st[i] != 2'd0)) rew_bad++;
                end else if (bus.state[2*i +: 2] == 2'd0 && prev_st[i] != 2'd0) begin
                    rew_bad++;
                end
            end
            prev_st[i] = bus.state[2*i +: 2];
        end
        prev_rst = reset;
    end

    task automatic set_btn(input logic [CH-1:0] chm, input logic g, input logic v);
        bus.btn_ch  = v ? chm : '0;
        bus.btn_all = g & v;
    endtask

    task automatic press(input logic [CH-1:0] chm, input logic g, input int dur, input logic bounce);
        if (bounce) begin
            for (int k = 0; k < 2; k++) begin
                set_btn(chm, g, 1'b1); @(negedge clk);
                set_btn(chm, g, 1'b0); @(negedge clk);
            end
        end
        set_btn(chm, g, 1'b1);
        repeat (dur) @(negedge clk);
        if (bounce) begin
            set_btn(chm, g, 1'b0); @(negedge clk);
            set_btn(chm, g, 1'b1); @(negedge clk);
        end
        set_btn(chm, g, 1'b0);
        repeat (SETTLE) @(negedge clk);
    endtask

    // Transport rules applied to a whole press: channel press beats global press for that channel.
    task automatic model_event(input logic [CH-1:0] chm, input logic g, input logic lng);
        int   pre [CH];
        logic any_play;
        pre      = exp_state;
        any_play = 1'b0;
        for (int c = 0; c < CH; c++) if (pre[c] == E_PLAY) any_play = 1'b1;
        for (int c = 0; c < CH; c++) begin
            if (chm[c] || g) begin
                if (lng) begin
                    if (pre[c] != E_STOP) begin
                        exp_state[c] = E_STOP;
                        exp_rew[c]++;
                    end
                end else if (chm[c]) begin
                    exp_state[c] = (pre[c] == E_PLAY) ? E_PAUSE : E_PLAY;
                end else if (any_play) begin
                    if (pre[c] == E_PLAY) exp_state[c] = E_PAUSE;
                end else if (pre[c] == E_PAUSE) begin
                    exp_state[c] = E_PLAY;
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < CH; c++) begin
            exp_state[c] = E_STOP;
            exp_rew[c]   = 0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            checks++;
            if ({bus.state, bus.run, bus.rewind} !== 8'h00) begin
                errors++;
                $display("FAIL reset cycle %0d state/run/rewind got %b want 00000000", n, {bus.state, bus.run, bus.rewind});
            end
        end
    endtask

    task automatic test_channel_press();
        for (int p = 0; p < 2; p++) begin
            press(2'b01, 1'b0, 10, 1'b0);
            model_event(2'b01, 1'b0, 1'b0);
            for (int c = 0; c < CH; c++) begin
                checks++;
                if ({bus.run[c], bus.state[2*c +: 2]} !== {exp_state[c] == E_PLAY, 2'(exp_state[c])}) begin
                    errors++;
                    $display("FAIL chan_press%0d ch%0d run,state got %b want %b", p, c,
                             {bus.run[c], bus.state[2*c +: 2]}, {exp_state[c] == E_PLAY, 2'(exp_state[c])});
                end
            end
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 20; k++) begin
            bus.btn_ch[1] = ~bus.btn_ch[1];
            repeat (2) @(negedge clk);
        end
        bus.btn_ch[1] = 1'b0;
        repeat (SETTLE) @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            checks++;
            if ({bus.run[c], bus.state[2*c +: 2]} !== {exp_state[c] == E_PLAY, 2'(exp_state[c])}) begin
                errors++;
                $display("FAIL glitch ch%0d run,state got %b want %b", c,
                         {bus.run[c], bus.state[2*c +: 2]}, {exp_state[c] == E_PLAY, 2'(exp_state[c])});
            end
        end
    endtask

    task automatic test_long_press();
        for (int k = 0; k < 3 && exp_state[0] != E_PLAY; k++) begin
            press(2'b01, 1'b0, 8, 1'b0);
            model_event(2'b01, 1'b0, 1'b0);
        end
        set_btn(2'b01, 1'b0, 1'b1);
        repeat (29) @(negedge clk);
        model_event(2'b01, 1'b0, LONG_EN);
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < CH; c++) begin
                checks++;
                if ({bus.run[c], bus.state[2*c +: 2]} !== {exp_state[c] == E_PLAY, 2'(exp_state[c])}) begin
                    errors++;
                    $display("FAIL long_press%0d ch%0d run,state got %b want %b", ph, c,
                             {bus.run[c], bus.state[2*c +: 2]}, {exp_state[c] == E_PLAY, 2'(exp_state[c])});
                end
                checks++;
                if (rew_cnt[c] !== exp_rew[c]) begin
                    errors++;
                    $display("FAIL long_press%0d ch%0d rewind pulses got %0d want %0d", ph, c, rew_cnt[c], exp_rew[c]);
                end
            end
            if (ph == 0) begin
                @(negedge clk);
                set_btn(2'b01, 1'b0, 1'b0);
                repeat (SETTLE) @(negedge clk);
            end
        end
    endtask

    task automatic test_global();
        for (int k = 0; k < 3 && exp_state[0] != E_PLAY; k++) begin
            press(2'b01, 1'b0, 8, 1'b0);
            model_event(2'b01, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3 && exp_state[1] != E_PAUSE; k++) begin
            press(2'b10, 1'b0, 8, 1'b0);
            model_event(2'b10, 1'b0, 1'b0);
        end
        for (int p = 0; p < 2; p++) begin
            press(2'b00, 1'b1, 8, 1'b0);
            model_event(2'b00, 1'b1, 1'b0);
            for (int c = 0; c < CH; c++) begin
                checks++;
                if ({bus.run[c], bus.state[2*c +: 2]} !== {exp_state[c] == E_PLAY, 2'(exp_state[c])}) begin
                    errors++;
                    $display("FAIL global%0d ch%0d run,state got %b want %b", p, c,
                             {bus.run[c], bus.state[2*c +: 2]}, {exp_state[c] == E_PLAY, 2'(exp_state[c])});
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < 3 && exp_state[c] != E_PLAY; k++) begin
                press(CH'(1 << c), 1'b0, 8, 1'b0);
                model_event(CH'(1 << c), 1'b0, 1'b0);
            end
        end
        press(2'b01, 1'b1, 8, 1'b0);
        model_event(2'b01, 1'b1, 1'b0);
        for (int c = 0; c < CH; c++) begin
            checks++;
            if ({bus.run[c], bus.state[2*c +: 2]} !== {exp_state[c] == E_PLAY, 2'(exp_state[c])}) begin
                errors++;
                $display("FAIL simultaneous ch%0d run,state got %b want %b", c,
                         {bus.run[c], bus.state[2*c +: 2]}, {exp_state[c] == E_PLAY, 2'(exp_state[c])});
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        set_btn(2'b01, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int c = 0; c < CH; c++) exp_state[c] = E_STOP;
        reset = 1'b1;
        repeat (30) @(negedge clk);
        set_btn(2'b01, 1'b0, 1'b0);
        repeat (30) @(negedge clk);
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < CH; c++) begin
                checks++;
                if ({bus.run[c], bus.state[2*c +: 2]} !== {exp_state[c] == E_PLAY, 2'(exp_state[c])}) begin
                    errors++;
                    $display("FAIL reset_mid_hold%0d ch%0d run,state got %b want %b", ph, c,
                             {bus.run[c], bus.state[2*c +: 2]}, {exp_state[c] == E_PLAY, 2'(exp_state[c])});
                end
                checks++;
                if (rew_cnt[c] !== exp_rew[c]) begin
                    errors++;
                    $display("FAIL reset_mid_hold%0d ch%0d rewind pulses got %0d want %0d", ph, c, rew_cnt[c], exp_rew[c]);
                end
            end
            if (ph == 0) begin
                press(2'b01, 1'b0, 8, 1'b0);
                model_event(2'b01, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic test_random();
        logic [CH-1:0] chm;
        logic          g, lng, bounce;
        int            dur;
        for (int n = 0; n < 24; n++) begin
            chm    = CH'($urandom_range(0, 3));
            g      = (chm == '0) ? 1'b1 : 1'($urandom_range(0, 1));
            lng    = ($urandom_range(0, 2) == 0);
            dur    = lng ? int'($urandom_range(24, 34)) : int'($urandom_range(6, 10));
            bounce = 1'($urandom_range(0, 1));
            press(chm, g, dur, bounce);
            model_event(chm, g, LONG_EN && lng);
            for (int c = 0; c < CH; c++) begin
                checks++;
                if ({bus.run[c], bus.state[2*c +: 2]} !== {exp_state[c] == E_PLAY, 2'(exp_state[c])}) begin
                    errors++;
                    $display("FAIL random%0d ch%0d (chm=%b g=%0d dur=%0d) run,state got %b want %b", n, c, chm, g, dur,
                             {bus.run[c], bus.state[2*c +: 2]}, {exp_state[c] == E_PLAY, 2'(exp_state[c])});
                end
                checks++;
                if (rew_cnt[c] !== exp_rew[c]) begin
                    errors++;
                    $display("FAIL random%0d ch%0d rewind pulses got %0d want %0d", n, c, rew_cnt[c], exp_rew[c]);
                end
            end
        end
    endtask

    task automatic test_rewind_integrity();
        checks++;
        if (rew_bad !== 0) begin
            errors++;
            $display("FAIL rewind_timing misplaced or missing pulses got %0d want 0", rew_bad);
        end
    endtask

    initial begin
        bus.btn_ch  = '0;
        bus.btn_all = 1'b0;
        reset       = 1'b0;
        test_reset();
        test_channel_press();
        test_glitch();
        test_long_press();
        test_global();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        test_rewind_integrity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/transport_ctrl.md
# transport_ctrl

Multi-channel play/pause/stop transport controller for the synth's sample/sequencer voices. It conditions one raw push-button per channel plus a global button, and classifies each press as short or long. It drives a per-channel three-state transport FSM and outputs run enables and rewind pulses to the playback engines. It generalises the single-channel play/pause toggle with parametrised channel count, debounce, a STOP state and global control.

## Interface
- CHANNELS, 4: number of independent transport channels (1..16)
- DEBOUNCE_CYCLES, 50000: cycles a synchronised input must be stable before the debounced level changes (≥2)
- HOLD_CYCLES, 25000000: debounced-press duration that qualifies as a long press (> DEBOUNCE_CYCLES)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_ch  in  CHANNELS  raw per-channel buttons, active-high, asynchronous to clk
- btn_all  in  1  raw global button, active-high, asynchronous
- run  out  CHANNELS  1 while channel is in PLAY
- rewind  out  CHANNELS  one-cycle pulse when channel enters STOP from PLAY or PAUSE
- state  out  2*CHANNELS  per-channel state code, channel i at [2i+1:2i]

## Operation
- Per-channel states: STOP=2'd0, PLAY=2'd1, PAUSE=2'd2; code 3 is illegal and recovers to STOP on the next clock.
- Button conditioning, per input: 2-flop synchroniser, then a stability counter. The debounced level takes the synchronised value after DEBOUNCE_CYCLES consecutive equal samples; any change restarts the count.
- Hold counter runs while the debounced level is 1 and saturates at HOLD_CYCLES.
- long pulse: one cycle when the hold count reaches HOLD_CYCLES, at most once per press.
- short pulse: one cycle on debounced release if long did not fire for that press.
- Channel short press: STOP→PLAY, PLAY→PAUSE, PAUSE→PLAY.
- Channel long press: PLAY or PAUSE→STOP with rewind; STOP stays STOP with no rewind.
- Global short press: if any channel is in PLAY, all PLAY channels go to PAUSE. Otherwise all PAUSE channels go to PLAY. STOP channels are untouched.
- Global long press: all non-STOP channels go to STOP with rewind.
- Simultaneous channel and global events in one cycle: the channel event wins for that channel. The global event applies to the other channels, using the "any PLAY" test on pre-update states.
- Reset mid-press: all counters clear, debounced levels go to 0, and no event is generated on the following release.

## Timing
- Reset values: state = all STOP, run = 0, rewind = 0, all debounced levels and counters = 0.
- Raw edge to debounced edge: 2 sync cycles + DEBOUNCE_CYCLES.
- Debounced release to short pulse: 1 cycle. Short or long pulse to state update: 1 cycle.
- run is a combinational decode of the registered state, so it changes in the same cycle as state.
- rewind is registered and asserts in the same cycle the state first reads STOP, for exactly 1 cycle.
- Glitches shorter than DEBOUNCE_CYCLES produce no event.

## Configuration
- TRANSPORT_LONG_PRESS_EN defined: short/long classification as above.
- Not defined: the hold counter is removed and no long events occur. Every debounced press edge (not release) acts as a short event, which reduces latency. STOP is reachable only via reset, and rewind is tied to 0.

## Structure
- Package synth_transport_pkg holds:
  - state encoding localparams (ST_STOP, ST_PLAY, ST_PAUSE)
  - transport_state_t typedef
  - a clog2-based width helper for the counters
- Sub-module button_conditioner contains the synchroniser, debounce, hold counter and short/long pulses. It is instantiated CHANNELS+1 times.
- The top level holds the CHANNELS FSMs and the global-event logic.

## Test plan
Bench parameters: CHANNELS=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=16.
- Reset released, no buttons → state=4'b0000, run=2'b00, rewind=2'b00 for 100 cycles.
- btn_ch[0] high 10 cycles then low → after release, ch0 STOP→PLAY, run=2'b01. Repeat → PAUSE, run=2'b00.
- btn_ch[1] toggling every 2 cycles for 40 cycles → no state change on ch1.
- ch0 in PLAY, btn_ch[0] held 30 cycles → ch0 goes STOP with a single rewind[0] pulse while still held; the release produces no short event.
- ch0 PLAY, ch1 PAUSE, btn_all short → both PAUSE. btn_all short again → both PLAY.
- ch0 and ch1 PLAY; btn_ch[0] short and btn_all short engineered to pulse in the same cycle → ch0 PAUSE via channel event, ch1 PAUSE via global event. Reset asserted mid-hold → all STOP, no event after the button is released.
